// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared fetch-stage types and constants
package mips_pkg;

  localparam int INST_W = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0]       pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch FIFO of {pc, inst} entries with flush
module fetch_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output fetch_entry_t           head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  // Storage is reset so the head reads as zero straight out of reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC owner, imem request FSM and prefetch buffer
module fetch_unit
  import mips_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                   clock,
  input  logic                   reset,
  output logic                   imem_req,
  output logic [31:0]            imem_addr,
  input  logic                   imem_ack,
  input  logic [INST_W-1:0]      imem_rdata,
  output logic                   inst_valid,
  output logic [INST_W-1:0]      inst,
  output logic [31:0]            inst_pc,
  output logic [31:0]            inst_pc_plus4,
  input  logic                   inst_ready,
  input  logic                   redirect,
  input  logic [31:0]            redirect_pc,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  fetch_state_t     state;
  fetch_state_t     state_nxt;
  logic [31:0]      fetch_pc;
  logic [31:0]      fetch_pc_nxt;
  logic [31:0]      addr_q;
  logic [31:0]      addr_nxt;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_after;
  logic             push;
  logic             pop;
  fetch_entry_t     push_entry;
  fetch_entry_t     head;

  assign pop         = inst_valid && inst_ready;
  assign push        = (state == WAIT) && imem_ack && !redirect;
  assign count_after = count + CNT_W'(push) - CNT_W'(pop);
  assign push_entry  = '{pc: fetch_pc, inst: imem_rdata};

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    if (redirect) begin
      fetch_pc_nxt = redirect_pc & ~32'd3;
      case (state)
        WAIT:    state_nxt = imem_ack ? IDLE : DROP;
        DROP:    state_nxt = imem_ack ? IDLE : DROP;
        default: state_nxt = IDLE;
      endcase
    end else begin
      case (state)
        IDLE: begin
          if (count < FULL) state_nxt = WAIT;
        end
        WAIT: begin
          if (imem_ack) begin
            fetch_pc_nxt = fetch_pc + 32'd4;
            state_nxt    = (count_after < FULL) ? WAIT : IDLE;
          end
        end
        DROP: begin
          if (imem_ack) state_nxt = WAIT;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // While a cancelled request is still outstanding the bus must keep its address.
  assign addr_nxt = (state_nxt == DROP) ? addr_q : fetch_pc_nxt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      addr_q   <= RESET_PC;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      addr_q   <= addr_nxt;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .push_data(push_entry),
    .pop      (pop),
    .flush    (redirect),
    .count    (count),
    .head     (head)
  );

  assign imem_req      = (state != IDLE);
  assign imem_addr     = addr_q;
  assign inst_valid    = (count != '0);
  assign inst          = head.inst;
  assign inst_pc       = head.pc;
  assign inst_pc_plus4 = head.pc + 32'd4;
  assign fifo_count    = count;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          CW       = $clog2(DEPTH) + 1;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          imem_req;
  logic [31:0]   imem_addr;
  logic          imem_ack;
  logic [31:0]   imem_rdata;
  logic          inst_valid;
  logic [31:0]   inst;
  logic [31:0]   inst_pc;
  logic [31:0]   inst_pc_plus4;
  logic          inst_ready  = 1'b0;
  logic          redirect    = 1'b0;
  logic [31:0]   redirect_pc = 32'd0;
  logic [CW-1:0] fifo_count;

  int total = 0;
  int bad   = 0;

  logic mem_auto = 1'b0;
  logic man_ack  = 1'b0;
  logic auto_ack = 1'b0;
  int   req_age  = 0;
  int   lat      = 0;

  fetch_unit #(
    .DEPTH   (DEPTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .inst_valid   (inst_valid),
    .inst         (inst),
    .inst_pc      (inst_pc),
    .inst_pc_plus4(inst_pc_plus4),
    .inst_ready   (inst_ready),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .fifo_count   (fifo_count)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[1:0], ~a[31:2]} ^ 32'h1357_9BDF;
  endfunction

  assign imem_rdata = mem_word(imem_addr);
  assign imem_ack   = mem_auto ? auto_ack : man_ack;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Variable-latency memory; junk ack while idle must be ignored by the DUT.
  always @(negedge clock) begin
    if (mem_auto) begin
      if (imem_req) begin
        if (req_age >= lat) begin
          auto_ack = 1'b1;
          req_age  = 0;
          lat      = $urandom_range(0, 3);
        end else begin
          auto_ack = 1'b0;
          req_age++;
        end
      end else begin
        auto_ack = 1'($urandom_range(0, 1));
        req_age  = 0;
      end
    end
  end

  // A request must stay up with a fixed address until acknowledged.
  logic        pend = 1'b0;
  logic [31:0] pend_addr = 32'd0;
  always @(posedge clock) begin
    if (!reset) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        chk("req_held", 32'(imem_req), 32'd1);
        chk("addr_stable", imem_addr, pend_addr);
      end
      pend      = imem_req && !imem_ack;
      pend_addr = imem_addr;
    end
  end

  // Reference model: buffered PCs as a queue, sequential refetch from each target.
  logic        model_on = 1'b0;
  logic [31:0] mq[$];
  logic [31:0] m_next  = RESET_PC;
  logic        m_stale = 1'b0;
  int          pops    = 0;
  always @(posedge clock) begin
    if (model_on) begin
      if (redirect) begin
        mq.delete();
        m_next  = redirect_pc & ~32'd3;
        m_stale = imem_req && !imem_ack;
      end else begin
        if (inst_ready && mq.size() != 0) begin
          void'(mq.pop_front());
          pops++;
        end
        if (imem_req && imem_ack) begin
          if (m_stale) begin
            m_stale = 1'b0;
          end else begin
            chk("m_ack_addr", imem_addr, m_next);
            mq.push_back(m_next);
            m_next = m_next + 32'd4;
          end
        end
      end
    end
  end

  task automatic model_cmp();
    chk("m_count", 32'(fifo_count), 32'(mq.size()));
    chk("m_valid", 32'(inst_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("m_pc", inst_pc, mq[0]);
      chk("m_inst", inst, mem_word(mq[0]));
      chk("m_pc4", inst_pc_plus4, mq[0] + 32'd4);
    end
    if (imem_req && !m_stale) chk("m_addr", imem_addr, m_next);
    chk("m_bound", 32'((int'(fifo_count) + int'(imem_req)) <= DEPTH), 32'd1);
  endtask

  task automatic do_reset();
    reset      = 1'b0;
    man_ack    = 1'b0;
    inst_ready = 1'b0;
    redirect   = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic cyc(input string tag, input logic ack, input logic rdy, input logic rd,
                     input logic [31:0] rpc, input logic e_req, input logic [31:0] e_addr,
                     input logic e_valid, input logic [31:0] e_pc, input int e_cnt);
    man_ack     = ack;
    inst_ready  = rdy;
    redirect    = rd;
    redirect_pc = rpc;
    @(posedge clock);
    #1;
    chk({tag, ".req"}, 32'(imem_req), 32'(e_req));
    chk({tag, ".addr"}, imem_addr, e_addr);
    chk({tag, ".valid"}, 32'(inst_valid), 32'(e_valid));
    chk({tag, ".count"}, 32'(fifo_count), 32'(e_cnt));
    if (e_valid) begin
      chk({tag, ".pc"}, inst_pc, e_pc);
      chk({tag, ".inst"}, inst, mem_word(e_pc));
      chk({tag, ".pc4"}, inst_pc_plus4, e_pc + 32'd4);
    end
    @(negedge clock);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".req"}, 32'(imem_req), 32'd0);
    chk({tag, ".addr"}, imem_addr, RESET_PC);
    chk({tag, ".valid"}, 32'(inst_valid), 32'd0);
    chk({tag, ".inst"}, inst, 32'd0);
    chk({tag, ".pc"}, inst_pc, 32'd0);
    chk({tag, ".pc4"}, inst_pc_plus4, 32'd4);
    chk({tag, ".count"}, 32'(fifo_count), 32'd0);
  endtask

  typedef struct {
    logic        ack;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    int          e_cnt;
  } vec_t;

  vec_t tbl[13];

  initial begin
    // Fill to DEPTH with the core stalled, then drain and resume from 16.
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 32'd0,  1'b0, 32'd0,  0};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 32'd4,  1'b1, 32'd0,  1};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 32'd8,  1'b1, 32'd0,  2};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 32'd12, 1'b1, 32'd0,  3};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 32'd16, 1'b1, 32'd0,  4};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 32'd16, 1'b1, 32'd0,  4};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 32'd16, 1'b1, 32'd4,  3};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 32'd16, 1'b1, 32'd4,  3};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 32'd20, 1'b1, 32'd4,  4};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 32'd20, 1'b1, 32'd8,  3};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 32'd20, 1'b1, 32'd12, 2};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 32'd24, 1'b1, 32'd16, 2};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 32'd28, 1'b1, 32'd20, 2};

    repeat (2) @(negedge clock);
    #1;
    chk_reset_outputs("reset");
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 13; i++) begin
      cyc($sformatf("tbl%0d", i), tbl[i].ack, tbl[i].rdy, 1'b0, 32'd0,
          tbl[i].e_req, tbl[i].e_addr, tbl[i].e_valid, tbl[i].e_pc, tbl[i].e_cnt);
    end

    // Redirect while the request to 8 is pending: its ack is dropped.
    do_reset();
    cyc("drop0", 1'b0, 1'b0, 1'b0, 32'd0,      1'b1, 32'd0,     1'b0, 32'd0,     0);
    cyc("drop1", 1'b1, 1'b0, 1'b0, 32'd0,      1'b1, 32'd4,     1'b1, 32'd0,     1);
    cyc("drop2", 1'b1, 1'b0, 1'b0, 32'd0,      1'b1, 32'd8,     1'b1, 32'd0,     2);
    cyc("drop3", 1'b0, 1'b1, 1'b1, 32'h103,    1'b1, 32'd8,     1'b0, 32'd0,     0);
    cyc("drop4", 1'b0, 1'b0, 1'b0, 32'd0,      1'b1, 32'd8,     1'b0, 32'd0,     0);
    cyc("drop5", 1'b1, 1'b0, 1'b0, 32'd0,      1'b1, 32'h100,   1'b0, 32'd0,     0);
    cyc("drop6", 1'b1, 1'b0, 1'b0, 32'd0,      1'b1, 32'h104,   1'b1, 32'h100,   1);

    // Redirect coinciding with an ack while two entries are buffered.
    do_reset();
    cyc("rack0", 1'b0, 1'b0, 1'b0, 32'd0,      1'b1, 32'd0,     1'b0, 32'd0,     0);
    cyc("rack1", 1'b1, 1'b0, 1'b0, 32'd0,      1'b1, 32'd4,     1'b1, 32'd0,     1);
    cyc("rack2", 1'b1, 1'b0, 1'b0, 32'd0,      1'b1, 32'd8,     1'b1, 32'd0,     2);
    cyc("rack3", 1'b1, 1'b0, 1'b1, 32'h200,    1'b0, 32'h200,   1'b0, 32'd0,     0);
    cyc("rack4", 1'b0, 1'b0, 1'b0, 32'd0,      1'b1, 32'h200,   1'b0, 32'd0,     0);
    cyc("rack5", 1'b1, 1'b0, 1'b0, 32'd0,      1'b1, 32'h204,   1'b1, 32'h200,   1);

    // PC wraps past the top of the address space.
    do_reset();
    cyc("wrap0", 1'b0, 1'b0, 1'b0, 32'd0,        1'b1, 32'd0,        1'b0, 32'd0,        0);
    cyc("wrap1", 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFA, 1'b0, 32'hFFFF_FFF8, 1'b0, 32'd0,        0);
    cyc("wrap2", 1'b1, 1'b0, 1'b0, 32'd0,        1'b1, 32'hFFFF_FFF8, 1'b0, 32'd0,        0);
    cyc("wrap3", 1'b1, 1'b0, 1'b0, 32'd0,        1'b1, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFF8, 1);
    cyc("wrap4", 1'b1, 1'b0, 1'b0, 32'd0,        1'b1, 32'd0,        1'b1, 32'hFFFF_FFF8, 2);
    cyc("wrap5", 1'b1, 1'b1, 1'b0, 32'd0,        1'b1, 32'd4,        1'b1, 32'hFFFF_FFFC, 2);
    cyc("wrap6", 1'b0, 1'b1, 1'b0, 32'd0,        1'b1, 32'd4,        1'b1, 32'd0,        1);

    // Asynchronous reset in the middle of an outstanding request.
    do_reset();
    cyc("mrst0", 1'b0, 1'b0, 1'b0, 32'd0,      1'b1, 32'd0,     1'b0, 32'd0,     0);
    cyc("mrst1", 1'b1, 1'b0, 1'b0, 32'd0,      1'b1, 32'd4,     1'b1, 32'd0,     1);
    man_ack = 1'b0;
    #2 reset = 1'b0;
    #1 chk_reset_outputs("midreset");
    @(negedge clock);
    reset = 1'b1;
    cyc("mrst2", 1'b0, 1'b0, 1'b0, 32'd0,      1'b1, RESET_PC,  1'b0, 32'd0,     0);

    // Randomized traffic against the queue model.
    do_reset();
    reset    = 1'b0;
    mem_auto = 1'b1;
    mq.delete();
    m_next   = RESET_PC;
    m_stale  = 1'b0;
    pops     = 0;
    @(negedge clock);
    reset    = 1'b1;
    model_on = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      model_cmp();
      inst_ready = ($urandom_range(0, 3) != 0);
      redirect   = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else redirect_pc = $urandom;
    end
    model_on = 1'b0;
    chk("liveness", 32'(pops > 200), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage upstream of the single-cycle MIPS core's decode/execute datapath. It owns the program counter, issues word reads to a variable-latency instruction memory over a req/ack handshake, and buffers returned instructions with their PC in a small prefetch FIFO. The FIFO drains to the core over a valid/ready handshake. A taken branch from the core redirects fetch and flushes all buffered and in-flight instructions.

## Interface
- DEPTH, 4: prefetch FIFO entries; power of two, ≥2
- RESET_PC, 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0
- clock  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- imem_req  out  1  instruction read request; held until imem_ack
- imem_addr  out  32  byte address of the requested word; always word aligned; stable while imem_req=1
- imem_ack  in  1  read complete this cycle; ignored when imem_req=0
- imem_rdata  in  32  instruction word; valid when imem_ack=1
- inst_valid  out  1  FIFO head holds a valid instruction
- inst  out  32  FIFO head instruction word
- inst_pc  out  32  address of inst
- inst_pc_plus4  out  32  inst_pc + 4, modulo 2^32
- inst_ready  in  1  core consumes the head this cycle when inst_valid=1
- redirect  in  1  taken branch/jump; flush and refetch
- redirect_pc  in  32  new fetch address; bits [1:0] forced to 0
- fifo_count  out  $clog2(DEPTH)+1  number of buffered entries

## Operation
- Registers: fetch_pc, FIFO storage (inst, pc), count, request state.
- Request FSM, 3 states:
  - IDLE: imem_req=0. Goes to WAIT when count < DEPTH and redirect=0.
  - WAIT: imem_req=1, imem_addr=fetch_pc. On imem_ack: push {imem_rdata, fetch_pc}, fetch_pc += 4. Then stays in WAIT, requesting the new fetch_pc, when the post-push/post-pop count < DEPTH; otherwise goes to IDLE.
  - DROP: imem_req=1, imem_addr still holds the abandoned address. This keeps the handshake legal while the request is cancelled. On imem_ack: response discarded, go to WAIT at fetch_pc.
- Invariant: count + outstanding request ≤ DEPTH. A push never overflows.
- Pop: inst_valid && inst_ready removes the head. A push and a pop in the same cycle leave count unchanged.
- Redirect, highest priority:
  - FIFO flushed (count=0), fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - From WAIT without ack in the same cycle: go to DROP.
  - From WAIT with ack in the same cycle: ack'd data discarded; go to IDLE.
  - From IDLE: stay in IDLE.
  - From DROP without ack: stay in DROP.
  - From DROP with ack: go to IDLE.
  - A pop in the same cycle as redirect is a completed handshake but has no further effect.
- A request is never withdrawn or its address changed before ack.
- fetch_pc wraps from 32'hFFFF_FFFC to 0 without error.

## Timing
- Reset (async assert) values: imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0, inst_pc_plus4=4, fifo_count=0, FSM=IDLE, fetch_pc=RESET_PC.
- First imem_req=1 on the first rising edge after reset deasserts.
- Reset asserted mid-request: imem_req drops immediately. The memory must tolerate an abandoned request on reset.
- Fetch latency: instruction acked at edge N gives inst_valid=1 from edge N. FIFO outputs are registered.
- Back-to-back: with imem_ack tied high and inst_ready=1, one instruction per cycle.
- Redirect at edge N: inst_valid=0 after N. The new address is first requested after N from IDLE, or after the ack in DROP.
- All outputs are registered. No combinational path from inst_ready, imem_ack or redirect to any output.

## Structure
- Shared package mips_pkg:
  - fetch FSM state enum (IDLE, WAIT, DROP)
  - DEFAULT_RESET_PC constant
  - INST_W = 32
- Sub-module fetch_fifo: synchronous FIFO with DEPTH entries of {pc[31:0], inst[31:0]}.
  - Ports: push, pop, flush, count, head.
  - flush has priority over push.
  - Head pointers wrap modulo DEPTH.

## Test plan
- Reset with RESET_PC=0, imem_ack always 1, inst_ready=1 → imem_addr runs 0, 4, 8, 12…; inst_pc matches, delayed one cycle; one inst per cycle; inst_pc_plus4 = inst_pc+4.
- inst_ready=0, ack always 1, DEPTH=4 → exactly 4 pushes, fifo_count=4, imem_req=0. Raise inst_ready → requests resume at address 16, with no loss or duplicate.
- Memory with 3-cycle ack latency → imem_addr stable for all 3 cycles. Each instruction appears once, in order.
- Redirect to 32'h0000_0103 while a request to 8 is pending → state DROP; the ack for 8 is dropped; next imem_addr=32'h100; first inst_pc after that is 32'h100.
- Redirect in the same cycle as an ack, with the FIFO holding 2 entries → fifo_count=0, inst_valid=0, the acked word never appears, and refetch starts at the redirect target.
- Reset asserted while imem_req=1 and FIFO partly full → all outputs at reset values immediately. After release, fetch restarts at RESET_PC.
